// File: rtl/quad_pkg.sv
// Quadrature state encodings, filter counter sizing and the transition classifier.
package quad_pkg;

  localparam int FILT_LEN_DFLT = 4;
  localparam int FCNT_W        = $clog2(FILT_LEN_DFLT + 1);

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  // Returns {legal, up}; a double-bit change or no change reports legal=0.
  function automatic logic [1:0] q_dir(input logic [1:0] prev, input logic [1:0] st);
    logic [1:0] up_nxt;
    logic [1:0] dn_nxt;
    case (prev)
      Q00:     begin up_nxt = Q01; dn_nxt = Q10; end
      Q01:     begin up_nxt = Q11; dn_nxt = Q00; end
      Q11:     begin up_nxt = Q10; dn_nxt = Q01; end
      default: begin up_nxt = Q00; dn_nxt = Q11; end
    endcase
    return {(st == up_nxt) || (st == dn_nxt), st == up_nxt};
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Per-channel synchroniser plus stability filter; filt_o follows the synced level
// after FILT_LEN consecutive differing cycles. No backpressure.
module quad_glitch_filter
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = FILT_LEN_DFLT,
  parameter int CNT_W       = FCNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  input  logic prime_i,
  output logic sync_o,
  output logic filt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign filt_o = filt_q;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (prime_i) begin
      filt_d = sync_o;
    end else if (sync_o != filt_q) begin
      if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        filt_d = sync_o;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder with 4x stepping, loadable modulo position count and sticky error.
// Input level to count update is SYNC_STAGES+FILT_LEN+1 edges; no backpressure.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = FILT_LEN_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             clear_err,
  output logic [WIDTH-1:0] count,
  output logic             step_valid,
  output logic             step_dir,
  output logic             error
);

  localparam int PCNT_W = $clog2(SYNC_STAGES + 2);
  localparam int CNT_W  = $clog2(FILT_LEN + 1);

  logic              a_s, b_s, filt_a, filt_b;
  logic [PCNT_W-1:0] pcnt_q;
  logic              primed_q;
  logic [1:0]        prev_q, st, dir;
  logic              changed, step_ev, bad_ev;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              step_valid_q, step_dir_q, error_q;

  quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .CNT_W(CNT_W)) u_filt_a (
    .clk(clk), .reset(reset), .raw_i(enc_a), .prime_i(!primed_q), .sync_o(a_s), .filt_o(filt_a)
  );

  quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .CNT_W(CNT_W)) u_filt_b (
    .clk(clk), .reset(reset), .raw_i(enc_b), .prime_i(!primed_q), .sync_o(b_s), .filt_o(filt_b)
  );

  assign st      = {filt_a, filt_b};
  assign dir     = q_dir(prev_q, st);
  assign changed = primed_q && (st != prev_q);
  assign step_ev = changed && dir[1];
  assign bad_ev  = changed && !dir[1];

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = data;
    end else if (step_ev) begin
      count_d = dir[0] ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end
  end

  // While priming, prev tracks the level the filters are loading so the first
  // primed cycle sees no spurious transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q       <= '0;
      primed_q     <= 1'b0;
      prev_q       <= Q00;
      count_q      <= '0;
      step_valid_q <= 1'b0;
      step_dir_q   <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      if (!primed_q) begin
        pcnt_q   <= pcnt_q + PCNT_W'(1);
        primed_q <= (pcnt_q == PCNT_W'(SYNC_STAGES));
        prev_q   <= {a_s, b_s};
      end else begin
        prev_q   <= st;
      end
      count_q      <= count_d;
      step_valid_q <= step_ev;
      if (step_ev) step_dir_q <= dir[0];
      if (bad_ev) error_q <= 1'b1;
      else if (clear_err) error_q <= 1'b0;
    end
  end

  assign count      = count_q;
  assign step_valid = step_valid_q;
  assign step_dir   = step_dir_q;
  assign error      = error_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboarded bench: stimulus pushes expected steps, a monitor pops them on step_valid.
module tb_quadrature_decoder;

  localparam int WIDTH = 64;
  localparam int SYNC  = 2;
  localparam int FL    = 4;
  localparam int LAT   = SYNC + FL + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enc_a = 1'b0, enc_b = 1'b0, load = 1'b0, clear_err = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic [WIDTH-1:0] count;
  logic             step_valid, step_dir, error;

  quadrature_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .FILT_LEN(FL)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .load(load), .data(data),
    .clear_err(clear_err), .count(count), .step_valid(step_valid), .step_dir(step_dir),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             dir;
    logic [WIDTH-1:0] cnt;
  } exp_t;

  exp_t             q[$];
  exp_t             mon_e;
  int               total = 0;
  int               bad = 0;
  logic [WIDTH-1:0] m_count;
  logic             m_err;
  logic [1:0]       m_st;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && step_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_step: got step_valid=1 count=%0h expected no step", count);
      end else begin
        mon_e = q.pop_front();
        chk1("step_dir", step_dir, mon_e.dir);
        chk("step_count", count, mon_e.cnt);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Gray position around the wheel: 00,01,11,10 are positions 0..3.
  function automatic int gpos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gst(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic push_exp(input logic d, input logic [WIDTH-1:0] c);
    exp_t e;
    e.dir = d;
    e.cnt = c;
    q.push_back(e);
  endtask

  task automatic do_step(input logic up, input int hold);
    m_st    = gst(gpos(m_st) + (up ? 1 : 3));
    m_count = up ? m_count + 1 : m_count - 1;
    push_exp(up, m_count);
    {enc_a, enc_b} = m_st;
    cyc(hold);
  endtask

  task automatic do_glitch(input logic on_a, input int g);
    {enc_a, enc_b} = m_st ^ (on_a ? 2'b10 : 2'b01);
    cyc(g);
    {enc_a, enc_b} = m_st;
    cyc(FL + 2);
  endtask

  task automatic do_illegal(input int hold);
    m_st  = ~m_st;
    m_err = 1'b1;
    {enc_a, enc_b} = m_st;
    cyc(hold);
  endtask

  task automatic settle();
    cyc(LAT + 3);
    for (int i = 0; i < 100 && q.size() != 0; i++) cyc(1);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL step_drain: got %0d pending steps expected 0", q.size());
    end
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load = 1'b1;
    data = v;
    cyc(1);
    load = 1'b0;
    m_count = v;
  endtask

  task automatic do_clear();
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
    m_err = 1'b0;
  endtask

  initial begin
    logic a_up;
    int   r;
    // Reset with both channels high.
    {enc_a, enc_b} = 2'b11;
    #1 reset = 1'b0;
    cyc(3);
    chk("rst_count", count, '0);
    chk1("rst_step_valid", step_valid, 1'b0);
    chk1("rst_step_dir", step_dir, 1'b0);
    chk1("rst_error", error, 1'b0);
    reset = 1'b1;
    m_st = 2'b11; m_count = '0; m_err = 1'b0;
    cyc(20);
    chk("prime_count", count, '0);
    chk1("prime_error", error, 1'b0);

    // Walk to 00, zero the count, then a full forward and reverse turn.
    do_step(1'b1, 10);
    do_step(1'b1, 10);
    settle();
    do_load('0);
    for (int i = 0; i < 4; i++) do_step(1'b1, 10);
    settle();
    chk("fwd_count", count, 64'd4);
    chk1("fwd_dir", step_dir, 1'b1);
    for (int i = 0; i < 4; i++) do_step(1'b0, 10);
    settle();
    chk("rev_count", count, 64'd0);
    chk1("rev_dir", step_dir, 1'b0);

    // Modulo wrap both ways.
    do_load({WIDTH{1'b1}});
    do_step(1'b1, 10);
    settle();
    chk("wrap_up", count, 64'd0);
    do_step(1'b0, 10);
    settle();
    chk("wrap_down", count, {WIDTH{1'b1}});

    // Glitch filter boundary on channel A: 3 cycles rejected, 4 cycles accepted.
    do_glitch(1'b1, FL - 1);
    settle();
    chk("glitch3_count", count, m_count);
    a_up = (gpos(m_st) % 2) == 1;
    do_step(a_up, FL);
    do_step(!a_up, 10);
    settle();
    chk("pulse4_count", count, m_count);

    // Illegal transitions and clear priority.
    do_illegal(10);
    settle();
    chk1("illegal_error", error, 1'b1);
    chk("illegal_count", count, m_count);
    do_clear();
    chk1("clear_error", error, 1'b0);
    m_st  = ~m_st;
    m_err = 1'b1;
    {enc_a, enc_b} = m_st;
    cyc(LAT - 1);
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
    chk1("set_beats_clear", error, 1'b1);
    settle();
    do_clear();
    chk1("clear_again", error, 1'b0);

    // Load landing on the same edge as a legal step.
    m_st = gst(gpos(m_st) + 1);
    push_exp(1'b1, 64'd100);
    {enc_a, enc_b} = m_st;
    cyc(LAT - 1);
    do_load(64'd100);
    settle();
    chk("load_step_count", count, 64'd100);

    // Randomised mix of steps, glitches, illegal moves and clears.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        do_step(1'($urandom_range(0, 1)), $urandom_range(FL, 12));
      end else if (r < 8) begin
        do_glitch(1'($urandom_range(0, 1)), $urandom_range(1, FL - 1));
      end else if (r == 8) begin
        do_illegal($urandom_range(FL + 1, 10));
        settle();
        chk1("rand_error", error, m_err);
      end else begin
        settle();
        do_clear();
        chk1("rand_clear", error, m_err);
      end
    end
    settle();
    chk("rand_count", count, m_count);
    chk1("rand_error_end", error, m_err);

    // Asynchronous reset in the middle of a pending step.
    do_illegal(2);
    settle();
    m_st = gst(gpos(m_st) + 1);
    {enc_a, enc_b} = m_st;
    cyc(3);
    #2 reset = 1'b0;
    #1;
    chk("arst_count", count, '0);
    chk1("arst_step_valid", step_valid, 1'b0);
    chk1("arst_step_dir", step_dir, 1'b0);
    chk1("arst_error", error, 1'b0);
    q.delete();
    cyc(2);
    reset = 1'b1;
    m_count = '0;
    m_err = 1'b0;
    cyc(20);
    chk("rerelease_count", count, '0);
    chk1("rerelease_error", error, 1'b0);
    do_step(1'b1, 10);
    settle();
    chk("post_reset_step", count, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
